// File: rtl/vga_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_checker
// Purpose  : VGA receive-side monitor; rebuilds pixel coordinates, checks
//            active geometry and accumulates a per-frame RGB checksum.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_checker #(
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 48,
  parameter int COORD_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               VGA_HS,
  input  logic               VGA_VS,
  input  logic               VGA_BLANK,
  input  logic [7:0]         VGA_R,
  input  logic [7:0]         VGA_G,
  input  logic [7:0]         VGA_B,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [23:0]        pix_rgb,
  output logic               frame_done,
  output logic               frame_ok,
  output logic [31:0]        frame_sum,
  output logic [15:0]        frame_count,
  output logic               err_hlen,
  output logic               err_vlen
);

  localparam logic [0:0] c_ALIGN = 1'b0;
  localparam logic [0:0] c_FRAME = 1'b1;

  localparam logic [COORD_W-1:0] c_XY_MAX = '1;
  localparam logic [COORD_W-1:0] c_ONE    = COORD_W'(1);
  localparam logic [COORD_W-1:0] c_H      = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] c_V      = COORD_W'(V_ACTIVE);

  logic [0:0]         r_state;
  logic               r_hs_q;
  logic               r_vs_q;
  logic               r_blank_q;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [31:0]        r_acc;
  logic               r_line_ok;

  logic [23:0]        w_rgb;
  logic               w_vs_edge;
  logic               w_hs_edge;
  logic               w_run_end;
  logic               w_accept;
  logic [COORD_W-1:0] w_x_pix;
  logic [31:0]        w_acc_pix;
  logic               w_line_close;
  logic               w_line_bad;
  logic [COORD_W-1:0] w_x_close;
  logic [COORD_W-1:0] w_y_close;
  logic               w_line_ok_next;
  logic               w_frame_ok;

  assign w_rgb     = {VGA_R, VGA_G, VGA_B};
  assign w_vs_edge = r_vs_q & ~VGA_VS;
  assign w_hs_edge = r_hs_q & ~VGA_HS;
  assign w_run_end = r_blank_q & ~VGA_BLANK;
  assign w_accept  = (r_state == c_FRAME) & VGA_BLANK & (r_x < c_H) & (r_y < c_V);

  // Pixel step first, then line close on the post-pixel x, so a pixel that
  // arrives on the same sample as a sync edge is still counted in its line.
  always_comb begin
    w_x_pix   = r_x;
    w_acc_pix = r_acc;
    if (VGA_BLANK) begin
      if (w_accept) begin
        w_x_pix   = r_x + c_ONE;
        w_acc_pix = r_acc + {8'h00, w_rgb};
      end else if (r_x != c_XY_MAX) begin
        w_x_pix = r_x + c_ONE;
      end
    end

    w_line_close = (w_run_end | w_hs_edge | w_vs_edge) & (w_x_pix != '0);
    w_line_bad   = w_line_close & (w_x_pix != c_H);

    w_x_close = w_x_pix;
    w_y_close = r_y;
    if (w_line_close) begin
      w_x_close = '0;
      if (r_y != c_XY_MAX) begin
        w_y_close = r_y + c_ONE;
      end
    end

    w_line_ok_next = r_line_ok & ~w_line_bad;
    w_frame_ok     = w_line_ok_next & (w_y_close == c_V);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= c_ALIGN;
      r_hs_q      <= 1'b1;
      r_vs_q      <= 1'b1;
      r_blank_q   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_line_ok   <= 1'b1;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_sum   <= '0;
      frame_count <= '0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_en) begin
        r_hs_q    <= VGA_HS;
        r_vs_q    <= VGA_VS;
        r_blank_q <= VGA_BLANK;
        case (r_state)
          c_ALIGN: begin
            if (w_vs_edge) begin
              r_state   <= c_FRAME;
              r_x       <= '0;
              r_y       <= '0;
              r_acc     <= '0;
              r_line_ok <= 1'b1;
            end
          end
          c_FRAME: begin
            if (w_accept) begin
              pix_valid <= 1'b1;
              pix_x     <= r_x;
              pix_y     <= r_y;
              pix_rgb   <= w_rgb;
            end
            if (w_line_bad) begin
              err_hlen <= 1'b1;
            end
            if (w_vs_edge) begin
              frame_done  <= 1'b1;
              frame_ok    <= w_frame_ok;
              frame_sum   <= w_acc_pix;
              frame_count <= frame_count + 16'd1;
              if (w_y_close != c_V) begin
                err_vlen <= 1'b1;
              end
              r_x       <= '0;
              r_y       <= '0;
              r_acc     <= '0;
              r_line_ok <= 1'b1;
            end else begin
              r_x       <= w_x_close;
              r_y       <= w_y_close;
              r_acc     <= w_acc_pix;
              r_line_ok <= w_line_ok_next;
            end
          end
          default: r_state <= c_ALIGN;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_checker
// Purpose  : Directed frame-level bench for vga_frame_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_checker;

  localparam int CW = 12;

  logic          clk;
  logic          reset;
  logic          pix_en;
  logic          VGA_HS, VGA_VS, VGA_BLANK;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic          pix_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic [23:0]   pix_rgb;
  logic          frame_done, frame_ok;
  logic [31:0]   frame_sum;
  logic [15:0]   frame_count;
  logic          err_hlen, err_vlen;

  vga_frame_checker #(.H_ACTIVE(64), .V_ACTIVE(48), .COORD_W(CW)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_sum(frame_sum),
    .frame_count(frame_count), .err_hlen(err_hlen), .err_vlen(err_vlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n_done = 0;
  int          exp_done = 0;
  int          cnt_valid = 0;
  int          last_cnt = 0;
  int          coord_err = 0;
  bit          exp_on = 1'b0;
  logic [31:0] model_sum = '0;
  logic [31:0] exp_sum = '0;
  logic        done_at_vs;
  logic        g_valid;
  logic [CW-1:0] g_x, g_y;

  always @(negedge clk) if (frame_done) n_done++;

  typedef struct {
    int   nlines;
    int   short_y;
    int   short_len;
    logic exp_ok;
    logic exp_hlen;
    logic exp_vlen;
    int   exp_valid;
  } frame_vec_t;

  frame_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One pix_en sample followed by one idle clk; outputs are read 1 time unit
  // after the sampling edge, where the registered pixel result appears.
  task automatic sample(input logic hs, input logic vs, input logic blank,
                        input int x, input int y, input bit exp);
    logic [7:0] xr;
    logic [7:0] yg;
    xr = 8'(x);
    yg = 8'(y);
    VGA_HS = hs; VGA_VS = vs; VGA_BLANK = blank;
    VGA_R = xr; VGA_G = yg; VGA_B = 8'h00;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    g_valid = pix_valid; g_x = pix_x; g_y = pix_y;
    done_at_vs = frame_done;
    if (pix_valid) cnt_valid++;
    if (pix_valid !== exp ||
        (exp && (pix_x !== CW'(x) || pix_y !== CW'(y) || pix_rgb !== {xr, yg, 8'h00})))
      coord_err++;
    if (exp) model_sum = model_sum + {8'h00, xr, yg, 8'h00};
    @(posedge clk); #1;
  endtask

  task automatic send_pixels(input int y, input int x0, input int x1);
    for (int x = x0; x < x1; x++)
      sample(1'b1, 1'b1, 1'b1, x, y, exp_on && x < 64 && y < 48);
  endtask

  task automatic line_end();
    sample(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    sample(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    sample(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic send_vs(input logic hs);
    logic d;
    sample(hs, 1'b0, 1'b0, 0, 0, 1'b0);
    d = done_at_vs;
    exp_sum = model_sum;
    model_sum = '0;
    last_cnt = cnt_valid;
    cnt_valid = 0;
    sample(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    done_at_vs = d;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_valid"},   32'(pix_valid),   32'd0);
    check({tag, "_pix_x"},       32'(pix_x),       32'd0);
    check({tag, "_pix_y"},       32'(pix_y),       32'd0);
    check({tag, "_pix_rgb"},     32'(pix_rgb),     32'd0);
    check({tag, "_frame_done"},  32'(frame_done),  32'd0);
    check({tag, "_frame_ok"},    32'(frame_ok),    32'd0);
    check({tag, "_frame_sum"},   frame_sum,        32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check({tag, "_err_hlen"},    32'(err_hlen),    32'd0);
    check({tag, "_err_vlen"},    32'(err_vlen),    32'd0);
  endtask

  task automatic check_frame(input string tag, input logic ok, input logic hl,
                             input logic vl, input int nvalid, input int cnt);
    check({tag, "_done_pulse"}, 32'(done_at_vs),  32'd1);
    check({tag, "_n_done"},     32'(n_done),      32'(exp_done));
    check({tag, "_frame_ok"},   32'(frame_ok),    32'(ok));
    check({tag, "_frame_sum"},  frame_sum,        exp_sum);
    check({tag, "_count"},      32'(frame_count), 32'(cnt));
    check({tag, "_err_hlen"},   32'(err_hlen),    32'(hl));
    check({tag, "_err_vlen"},   32'(err_vlen),    32'(vl));
    check({tag, "_nvalid"},     32'(last_cnt),    32'(nvalid));
    check({tag, "_coord_err"},  32'(coord_err),   32'd0);
  endtask

  initial begin
    vecs[0] = '{48, -1, 64, 1'b1, 1'b0, 1'b0, 3072};
    vecs[1] = '{48, -1, 64, 1'b1, 1'b0, 1'b0, 3072};
    vecs[2] = '{48, 10, 63, 1'b0, 1'b1, 1'b0, 3071};
    vecs[3] = '{48, -1, 64, 1'b1, 1'b1, 1'b0, 3072};
    vecs[4] = '{50, -1, 64, 1'b0, 1'b1, 1'b1, 3072};
    vecs[5] = '{48, -1, 64, 1'b1, 1'b1, 1'b1, 3072};

    reset = 1'b0; pix_en = 1'b0;
    VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK = 1'b0;
    VGA_R = 8'h00; VGA_G = 8'h00; VGA_B = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // Active data before the first VS must be ignored entirely.
    exp_on = 1'b0;
    send_pixels(0, 0, 64);
    line_end();
    check("prealign_valid", 32'(cnt_valid), 32'd0);
    send_vs(1'b1);
    check("align_no_done", 32'(done_at_vs), 32'd0);
    check("align_n_done", 32'(n_done), 32'd0);
    check("prealign_coord_err", 32'(coord_err), 32'd0);
    exp_on = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int y = 0; y < vecs[i].nlines; y++) begin
        send_pixels(y, 0, (y == vecs[i].short_y) ? vecs[i].short_len : 64);
        line_end();
      end
      send_vs(1'b1);
      exp_done++;
      check_frame($sformatf("vec%0d", i), vecs[i].exp_ok, vecs[i].exp_hlen,
                  vecs[i].exp_vlen, vecs[i].exp_valid, i + 1);
    end

    // Line 47 still open when HS and VS fall together.
    for (int y = 0; y < 47; y++) begin
      send_pixels(y, 0, 64);
      line_end();
    end
    send_pixels(47, 0, 64);
    send_vs(1'b0);
    exp_done++;
    check_frame("simul", 1'b1, 1'b1, 1'b1, 3072, 7);
    sample(1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
    check("simul_next_valid", 32'(g_valid), 32'd1);
    check("simul_next_x", 32'(g_x), 32'd0);
    check("simul_next_y", 32'(g_y), 32'd0);

    // Run on to pixel (20,5), then reset on that very sample.
    send_pixels(0, 1, 64);
    line_end();
    for (int y = 1; y < 5; y++) begin
      send_pixels(y, 0, 64);
      line_end();
    end
    send_pixels(5, 0, 20);
    VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK = 1'b1;
    VGA_R = 8'd20; VGA_G = 8'd5; VGA_B = 8'h00;
    pix_en = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    pix_en = 1'b0;
    check_zero("rstmid");
    reset = 1'b1;
    @(posedge clk); #1;
    model_sum = '0; cnt_valid = 0; exp_on = 1'b0;

    send_pixels(0, 0, 64);
    line_end();
    send_vs(1'b1);
    check("rst_align_no_done", 32'(done_at_vs), 32'd0);
    check("rst_align_n_done", 32'(n_done), 32'(exp_done));
    exp_on = 1'b1;
    for (int y = 0; y < 48; y++) begin
      send_pixels(y, 0, 64);
      line_end();
    end
    send_vs(1'b1);
    exp_done++;
    check_frame("post_rst", 1'b1, 1'b0, 1'b0, 3072, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_frame_checker.md
# vga_frame_checker

Receive-side monitor for the VGA pixel stream produced by the Mandelbrot renderer. It samples HS/VS/BLANK/RGB on a pixel strobe and rebuilds (x, y) coordinates for every active pixel. It also checks the active-region geometry against H_ACTIVE×V_ACTIVE and reports a per-frame checksum. It sits in the bench or debug path, directly on the VGA output pins of the generator.

## Interface
- H_ACTIVE, 64: expected active pixels per line.
- V_ACTIVE, 48: expected active lines per frame.
- COORD_W, 12: width of the pix_x/pix_y coordinates.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- pix_en  in  1  one-cycle strobe marking a valid VGA pixel sample; inputs are ignored when low.
- VGA_HS  in  1  horizontal sync, active-low.
- VGA_VS  in  1  vertical sync, active-low.
- VGA_BLANK  in  1  1 = active video, 0 = blanking.
- VGA_R, VGA_G, VGA_B  in  8 each  pixel colour.
- pix_valid  out  1  one-cycle pulse for each accepted active pixel.
- pix_x, pix_y  out  COORD_W each  coordinates of the accepted pixel.
- pix_rgb  out  24  {R,G,B} of the accepted pixel.
- frame_done  out  1  one-cycle pulse at the end of each checked frame.
- frame_ok  out  1  result of the last frame; valid from frame_done onward.
- frame_sum  out  32  additive checksum of {R,G,B} over the last frame's accepted pixels.
- frame_count  out  16  number of completed frames; wraps at 2^16.
- err_hlen  out  1  sticky: some line had an active-pixel count ≠ H_ACTIVE.
- err_vlen  out  1  sticky: some frame had an active-line count ≠ V_ACTIVE.

## Operation
- Every action occurs only on cycles with pix_en=1. hs_q, vs_q and blank_q hold the previous sample.
- VS edge is vs_q=1 with VGA_VS=0. HS edge is hs_q=1 with VGA_HS=0. Active-run end is blank_q=1 with VGA_BLANK=0.
- FSM states:
  - ALIGN: entered on reset. Ignores all data. Moves to FRAME on the first VS edge and clears x, y, acc_sum.
  - FRAME: counts pixels and lines. On a VS edge it closes the frame, restarts x, y and acc_sum, and stays in FRAME.
- In FRAME, a sample with VGA_BLANK=1:
  - x < H_ACTIVE and y < V_ACTIVE: accept the pixel. pix_valid, pix_x=x, pix_y=y and pix_rgb are registered. acc_sum += {R,G,B} (zero-extended, mod 2^32). x increments.
  - Otherwise: no pix_valid. x keeps counting, saturating at 2^COORD_W−1.
- Active-run end or HS edge while x≠0 closes the line:
  - x≠H_ACTIVE sets err_hlen and clears line_ok_frame.
  - y increments, saturating at 2^COORD_W−1, and x is cleared.
- Frame close happens on a VS edge in FRAME:
  - An open line (x≠0) is closed first, using the line-close rules above.
  - frame_ok = line_ok_frame AND (y_after_close == V_ACTIVE). A mismatch sets err_vlen.
  - frame_sum = acc_sum including any pixel accepted on the same sample. frame_count increments. frame_done pulses.
- Simultaneous HS and VS edges: the frame is closed, then the new frame starts at x=0, y=0.
- err_hlen and err_vlen clear only on reset.

## Timing
- Reset values: pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, frame_done=0, frame_ok=0, frame_sum=0, frame_count=0, err_hlen=0, err_vlen=0, state=ALIGN, hs_q=vs_q=1, blank_q=0.
- pix_valid, pix_x, pix_y and pix_rgb are registered 1 clk after the accepting pix_en sample. pix_valid is high for exactly 1 clk.
- frame_done is high 1 clk after the sample carrying the VS edge, for exactly 1 clk. frame_ok, frame_sum and frame_count update in that same cycle and hold until the next frame_done.
- With pix_en held high, a pixel can be accepted every clk, so throughput is 1 pixel/clk. pix_en gaps stall all state.
- Reset asserted mid-frame: on the next clk every output returns to its reset value and the FSM returns to ALIGN. No frame_done is produced for the partial frame.
- The first VS edge after reset only aligns; it produces no frame_done.

## Test plan
- Nominal frame: after reset, drive 2 frames of 64×48 active pixels with RGB = {x,y,8'h00} and pix_en every other clk. Required: 3072 pix_valid pulses per frame with correct coordinates; frame_done ×1 per closed frame; frame_ok=1; frame_sum equal to the model sum; frame_count increments from 1 to 2; no error flags.
- Short line: line 10 carries 63 active pixels. Required: err_hlen=1 and frame_ok=0 for that frame; the next good frame gives frame_ok=1 while err_hlen stays 1.
- Extra lines: a frame with 50 active lines. Required: pix_valid only for y≤47; err_vlen=1; frame_ok=0.
- Pre-align data: active pixels before the first VS edge. Required: no pix_valid and no frame_done until the first VS edge.
- Simultaneous HS/VS edge with an open line of 64 pixels on line 47. Required: the line is counted, frame_ok=1, and the next pixel reports x=0, y=0.
- Reset mid-frame at pixel (20,5). Required: all outputs are 0 one clk later; no frame_done until 2 VS edges have followed the release of reset.
